hybrid_seq_ctrl: RTL and testbench

//  Sequencer for the hybrid fixed-point filter datapath, on the single full-rate clock.

---
 rtl/hybrid_ctrl_pkg.sv | 16 +
 rtl/hybrid_phase_cnt.sv | 32 +++
 rtl/hybrid_seq_ctrl.sv | 94 +++++++++
 tb/tb_hybrid_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hybrid_ctrl_pkg.sv
// rtl/hybrid_ctrl_pkg.sv - shared types and helpers for the hybrid filter sequencer
package hybrid_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        COMPUTE,
        RUN
    } ctrl_state_t;

    // Width of the warm-up counter, which must be able to hold VALID_TIME itself.
    function automatic int warm_width(input int valid_time);
        return $clog2(valid_time + 1);
    endfunction

endpackage

// File: rtl/hybrid_phase_cnt.sv
// rtl/hybrid_phase_cnt.sv - downsample phase counter with one-cycle sample tick
module hybrid_phase_cnt #(
    parameter int DSR = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clr,
    output logic [$clog2(DSR)-1:0] pos,
    output logic                   tick
);

    localparam int PW = $clog2(DSR);
    localparam logic [PW-1:0] LAST = PW'(DSR - 1);

    // tick is high in the cycle following the wrap edge, so it lines up with pos==0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pos  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            pos  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            tick <= (pos == LAST);
            pos  <= (pos == LAST) ? '0 : pos + PW'(1);
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/hybrid_seq_ctrl.sv
// rtl/hybrid_seq_ctrl.sv - warm-up FSM, warm count and result handshake for the hybrid filter
module hybrid_seq_ctrl
    import hybrid_ctrl_pkg::*;
#(
    parameter int DSR        = 12,
    parameter int COMP_TIME  = 8,
    parameter int VALID_TIME = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   flush,
    output logic [$clog2(DSR)-1:0] pos,
    output logic                   ds_tick,
    output logic                   valid_compute,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overrun
);

    localparam int WW = warm_width(VALID_TIME);
    localparam logic [WW-1:0] COMP_W  = WW'(COMP_TIME);
    localparam logic [WW-1:0] VALID_W = WW'(VALID_TIME);

    ctrl_state_t   state;
    ctrl_state_t   state_nx;
    logic [WW-1:0] wc;
    logic [WW-1:0] wc_nx;
    logic          step;

    hybrid_phase_cnt #(
        .DSR (DSR)
    ) u_phase (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (flush),
        .pos  (pos),
        .tick (ds_tick)
    );

    assign step = en && ds_tick;

    // VALID_W is checked before COMP_W so equal thresholds jump straight from FILL to RUN.
    always_comb begin
        wc_nx    = wc;
        state_nx = state;
        if (step && wc != VALID_W) begin
            wc_nx = wc + WW'(1);
        end
        case (state)
            IDLE:    if (en) state_nx = FILL;
            FILL: begin
                if (step && wc_nx == VALID_W)     state_nx = RUN;
                else if (step && wc_nx == COMP_W) state_nx = COMPUTE;
            end
            COMPUTE: if (step && wc_nx == VALID_W) state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            wc            <= '0;
            valid_compute <= 1'b0;
            out_valid     <= 1'b0;
            overrun       <= 1'b0;
        end else if (flush) begin
            state         <= en ? FILL : IDLE;
            wc            <= '0;
            valid_compute <= 1'b0;
            out_valid     <= 1'b0;
            overrun       <= 1'b0;
        end else if (en) begin
            state         <= state_nx;
            wc            <= wc_nx;
            valid_compute <= (state_nx == COMPUTE) || (state_nx == RUN);
            // Only ticks that arrive while already in RUN produce results.
            if (state == RUN) begin
                if (ds_tick) begin
                    if (out_valid && !out_ready) begin
                        overrun <= 1'b1;
                    end
                    out_valid <= 1'b1;
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hybrid_seq_ctrl.sv
// tb/tb_hybrid_seq_ctrl.sv - self-checking bench for hybrid_seq_ctrl
module tb_hybrid_seq_ctrl;

    localparam int DSR = 12;
    localparam int CT  = 8;
    localparam int VT  = 9;
    localparam int PW  = $clog2(DSR);

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          flush;
    logic          out_ready;
    logic [PW-1:0] pos;
    logic          ds_tick;
    logic          valid_compute;
    logic          out_valid;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    // Reference model: enabled edges since restart, ticks consumed, result flags.
    int m_n   = 0;
    int m_k   = 0;
    bit m_tick = 1'b0;
    bit m_ov  = 1'b0;
    bit m_ovr = 1'b0;

    hybrid_seq_ctrl #(
        .DSR        (DSR),
        .COMP_TIME  (CT),
        .VALID_TIME (VT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .flush         (flush),
        .pos           (pos),
        .ds_tick       (ds_tick),
        .valid_compute (valid_compute),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic e, input logic f, input logic rd);
        rst       = r;
        en        = e;
        flush     = f;
        out_ready = rd;
        if (!r || f) begin
            m_n = 0; m_k = 0; m_tick = 1'b0; m_ov = 1'b0; m_ovr = 1'b0;
        end else if (e) begin
            if (m_tick) begin
                m_k++;
                if (m_k > VT) begin
                    if (m_ov && !rd) m_ovr = 1'b1;
                    m_ov = 1'b1;
                end
            end else if (m_ov && rd) begin
                m_ov = 1'b0;
            end
            m_n++;
            m_tick = (m_n % DSR == 0);
        end else begin
            m_tick = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (pos !== '0) begin errors++; $display("FAIL reset_pos got %0d want 0", pos); end
        checks++; if (ds_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", ds_tick); end
        checks++; if (valid_compute !== 1'b0) begin errors++; $display("FAIL reset_vc got %b want 0", valid_compute); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    endtask

    task automatic test_warmup();
        int first_vc = -1;
        int first_ov = -1;
        for (int c = 1; c <= 130; c++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1);
            checks++;
            if (pos !== PW'(c % DSR)) begin errors++; $display("FAIL warm_pos cycle %0d got %0d want %0d", c, pos, c % DSR); end
            checks++;
            if (ds_tick !== (c % DSR == 0)) begin errors++; $display("FAIL warm_tick cycle %0d got %b want %b", c, ds_tick, c % DSR == 0); end
            if (valid_compute === 1'b1 && first_vc < 0) first_vc = c;
            if (out_valid === 1'b1 && first_ov < 0) first_ov = c;
        end
        checks++;
        if (first_vc != CT * DSR + 1) begin errors++; $display("FAIL warm_vc_latency got %0d want %0d", first_vc, CT * DSR + 1); end
        checks++;
        if (first_ov != VT * DSR + DSR + 1) begin errors++; $display("FAIL warm_first_valid got %0d want %0d", first_ov, VT * DSR + DSR + 1); end
    endtask

    task automatic test_pause();
        int n = 0;
        int gap = 0;
        while (pos !== PW'(7) && n < 2 * DSR) begin drive(1'b1, 1'b1, 1'b0, 1'b1); n++; end
        checks++; if (pos !== PW'(7)) begin errors++; $display("FAIL pause_reach_pos got %0d want 7", pos); end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1);
            checks++; if (pos !== PW'(7)) begin errors++; $display("FAIL pause_pos got %0d want 7", pos); end
            checks++; if (ds_tick !== 1'b0) begin errors++; $display("FAIL pause_tick got %b want 0", ds_tick); end
        end
        while (gap < 30) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1);
            gap++;
            if (ds_tick === 1'b1) break;
        end
        checks++; if (gap != DSR - 7) begin errors++; $display("FAIL pause_resume_gap got %0d want %0d", gap, DSR - 7); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int last = -1;
        int nint = 0;
        while ((out_valid === 1'b1 || ds_tick === 1'b1) && n < 30) begin drive(1'b1, 1'b1, 1'b0, 1'b1); n++; end
        n = 0;
        while (out_valid !== 1'b1 && n < 30) begin drive(1'b1, 1'b1, 1'b0, 1'b0); n++; end
        n = 0;
        while (ds_tick !== 1'b1 && n < 30) begin drive(1'b1, 1'b1, 1'b0, 1'b0); n++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_pending got %b want 1", out_valid); end
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", out_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b want 0", overrun); end
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", out_valid); end
        for (int c = 1; c <= 40; c++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1);
            if (out_valid === 1'b1) begin
                if (last >= 0) begin
                    nint++;
                    checks++;
                    if (c - last != DSR) begin errors++; $display("FAIL b2b_interval got %0d want %0d", c - last, DSR); end
                end
                last = c;
            end
        end
        checks++; if (nint < 2) begin errors++; $display("FAIL b2b_result_count got %0d want >=2", nint); end
    endtask

    task automatic test_overrun();
        int n = 0;
        int ticks = 0;
        bit t;
        while ((out_valid === 1'b1 || ds_tick === 1'b1) && n < 30) begin drive(1'b1, 1'b1, 1'b0, 1'b1); n++; end
        n = 0;
        while (ticks < 2 && n < 40) begin
            t = (ds_tick === 1'b1);
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            n++;
            if (t) begin
                ticks++;
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid tick %0d got %b want 1", ticks, out_valid); end
                checks++;
                if (overrun !== (ticks == 2)) begin errors++; $display("FAIL ovr_flag tick %0d got %b want %b", ticks, overrun, ticks == 2); end
            end
        end
        checks++; if (ticks != 2) begin errors++; $display("FAIL ovr_tick_count got %0d want 2", ticks); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1);
            checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun); end
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 30) begin drive(1'b1, 1'b1, 1'b0, 1'b0); n++; end
    endtask

    task automatic test_flush();
        int first_vc = -1;
        int nt = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got %b want 1", out_valid); end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        checks++; if (pos !== '0) begin errors++; $display("FAIL flush_pos got %0d want 0", pos); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", out_valid); end
        checks++; if (valid_compute !== 1'b0) begin errors++; $display("FAIL flush_vc got %b want 0", valid_compute); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL flush_overrun got %b want 0", overrun); end
        checks++; if (ds_tick !== 1'b0) begin errors++; $display("FAIL flush_tick got %b want 0", ds_tick); end
        for (int c = 1; c <= 110; c++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1);
            if (valid_compute === 1'b1) begin first_vc = c; break; end
            if (ds_tick === 1'b1) nt++;
        end
        checks++; if (first_vc != CT * DSR + 1) begin errors++; $display("FAIL flush_vc_latency got %0d want %0d", first_vc, CT * DSR + 1); end
        checks++; if (nt != CT) begin errors++; $display("FAIL flush_ticks_to_compute got %0d want %0d", nt, CT); end
    endtask

    task automatic test_reset_mid();
        int first_vc = -1;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (valid_compute !== 1'b1) begin errors++; $display("FAIL rmid_pre_vc got %b want 1", valid_compute); end
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        checks++; if (pos !== '0) begin errors++; $display("FAIL rmid_pos got %0d want 0", pos); end
        checks++; if (ds_tick !== 1'b0) begin errors++; $display("FAIL rmid_tick got %b want 0", ds_tick); end
        checks++; if (valid_compute !== 1'b0) begin errors++; $display("FAIL rmid_vc got %b want 0", valid_compute); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", out_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rmid_overrun got %b want 0", overrun); end
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (pos !== PW'(1)) begin errors++; $display("FAIL rmid_release_pos got %0d want 1", pos); end
        for (int c = 2; c <= 110; c++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1);
            if (valid_compute === 1'b1) begin first_vc = c; break; end
        end
        checks++; if (first_vc != CT * DSR + 1) begin errors++; $display("FAIL rmid_vc_latency got %0d want %0d", first_vc, CT * DSR + 1); end
    endtask

    task automatic test_random();
        logic r, e, f, rd;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom % 1000) != 0;
            e  = ($urandom % 5) != 0;
            f  = ($urandom % 400) == 0;
            rd = ($urandom % 3) != 0;
            drive(r, e, f, rd);
            checks++;
            if (pos !== PW'(m_n % DSR)) begin errors++; $display("FAIL rnd_pos cycle %0d got %0d want %0d", i, pos, m_n % DSR); end
            checks++;
            if (ds_tick !== m_tick) begin errors++; $display("FAIL rnd_tick cycle %0d got %b want %b", i, ds_tick, m_tick); end
            checks++;
            if (valid_compute !== (m_k >= CT)) begin errors++; $display("FAIL rnd_vc cycle %0d got %b want %b", i, valid_compute, m_k >= CT); end
            checks++;
            if (out_valid !== m_ov) begin errors++; $display("FAIL rnd_valid cycle %0d got %b want %b", i, out_valid, m_ov); end
            checks++;
            if (overrun !== m_ovr) begin errors++; $display("FAIL rnd_overrun cycle %0d got %b want %b", i, overrun, m_ovr); end
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_pause();
        test_back_to_back();
        test_overrun();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
